// File: rtl/fp_adder_pkg.sv
// Shared constants and types for the single-precision FP adder datapath.
package fp_adder_pkg;

  localparam int unsigned EXP_W        = 8;
  localparam int unsigned MANT_W       = 24;
  localparam int unsigned EXP_MIN_NORM = 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } norm_state_e;

endpackage

// File: rtl/controlled_decrementor.sv
// Exponent decrement-by-one gated by an enable; counterpart of the controlled incrementor.
module controlled_decrementor #(
  parameter int unsigned W = fp_adder_pkg::EXP_W
) (
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    if (en_i) begin
      y_o = a_i - W'(1);
    end
  end

endmodule

// File: rtl/controlled_decrement_normalizer.sv
// Sequential post-subtraction normalizer: one left shift and exponent decrement per cycle
// until the hidden bit is set, the mantissa is zero, or the denormal floor is reached.
module controlled_decrement_normalizer #(
  parameter int unsigned EXP_W  = fp_adder_pkg::EXP_W,
  parameter int unsigned MANT_W = fp_adder_pkg::MANT_W,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [EXP_W-1:0]  in_exp_i,
  input  logic [MANT_W-1:0] in_mant_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [EXP_W-1:0]  out_exp_o,
  output logic [MANT_W-1:0] out_mant_o,
  output logic [CNT_W-1:0]  out_shift_o,
  output logic              out_zero_o,
  output logic              out_denorm_o
);

  import fp_adder_pkg::*;

  norm_state_e       state_q, state_d;
  logic [EXP_W-1:0]  exp_q, exp_d, exp_dec;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              zero_q, zero_d;
  logic              denorm_q, denorm_d;
  logic              valid_q, valid_d;
  logic              dec_en;

  controlled_decrementor #(
    .W (EXP_W)
  ) u_exp_dec (
    .en_i (dec_en),
    .a_i  (exp_q),
    .y_o  (exp_dec)
  );

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    valid_d  = valid_q;
    dec_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          exp_d    = in_exp_i;
          mant_d   = in_mant_i;
          cnt_d    = '0;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (mant_q == '0) begin
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = StDone;
        end else if (mant_q[MANT_W-1]) begin
          state_d = StDone;
        end else if (exp_q == '0) begin
          denorm_d = 1'b1;
          state_d  = StDone;
        end else if (exp_q == EXP_W'(EXP_MIN_NORM)) begin
          // Exponents 0 and 1 share a scale, so the drop to 0 needs no shift.
          exp_d    = '0;
          denorm_d = 1'b1;
          state_d  = StDone;
        end else begin
          dec_en = 1'b1;
          exp_d  = exp_dec;
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        // First DONE cycle raises valid; the working registers are frozen from here on.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (out_ready_i) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      exp_q    <= '0;
      mant_q   <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
      valid_q  <= valid_d;
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign out_valid_o  = valid_q;
  assign out_exp_o    = exp_q;
  assign out_mant_o   = mant_q;
  assign out_shift_o  = cnt_q;
  assign out_zero_o   = zero_q;
  assign out_denorm_o = denorm_q;

  a_no_exp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    dec_en |-> (exp_q != '0));
  a_zero_denorm_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(zero_q && denorm_q));

endmodule
